plyr_frame_writer: RTL and testbench

Responder side of the player handshake: accepts player move requests (go_plyr, address, data) from the catcher control block, erases the catcher's previous cell, checks the target cell for a falling object, writes the new catcher cell and returns done_plyr. Owns the 8x8 frame memory (64 x 8 bit). Provides a write port for the falling-object generator and a registered read port for the LED matrix scanner.

---
 rtl/plyr_frame_writer.sv | 208 ++++++++++++++++++++
 tb/tb_plyr_frame_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/plyr_frame_writer.sv
// ---------------------------------------------------------------------------
// plyr_frame_writer
//
// Responder side of the player handshake. Owns the 8x8 frame memory
// (64 cells x 8 bit). For each player move request it erases the catcher's
// previous cell, reads the target cell to detect a falling object, writes the
// new catcher cell and pulses done_plyr. Also provides an object write port
// for the falling-object generator and a registered scanner read port.
//
// Optional feature macro: PLYR_HIT_CNT_EN
//   defined     -> 8-bit saturating hit_count
//   not defined -> hit_count tied to 0 (hit pulse unchanged)
//
// Ports:
//   clock, reset               system clock, async active-high reset
//   go_plyr                    player request valid (level)
//   plyr_addr, plyr_data       requested catcher cell / value to write there
//   done_plyr                  one-cycle completion pulse (registered)
//   busy                       high whenever the FSM is not IDLE (registered)
//   hit                        one-cycle pulse: catcher landed on a lit cell
//   hit_count                  saturating catch counter
//   obj_we, obj_addr, obj_data object write port
//   obj_ready                  object write accepted this cycle when high
//   rd_addr, rd_data           scanner read port, one-cycle latency
// ---------------------------------------------------------------------------
module plyr_frame_writer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go_plyr,
  input  logic [ADDR_W-1:0] plyr_addr,
  input  logic [DATA_W-1:0] plyr_data,
  output logic              done_plyr,
  output logic              busy,
  output logic              hit,
  output logic [7:0]        hit_count,
  input  logic              obj_we,
  input  logic [ADDR_W-1:0] obj_addr,
  input  logic [DATA_W-1:0] obj_data,
  output logic              obj_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERASE = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   req_addr_q,  req_addr_d;
  logic [DATA_W-1:0]   req_data_q,  req_data_d;
  logic [ADDR_W-1:0]   cur_addr_q,  cur_addr_d;
  logic                cur_valid_q, cur_valid_d;
  logic [DATA_W-1:0]   rd_int_q,    rd_int_d;
  logic                hit_q,       hit_d;
  logic                done_q,      done_d;
  logic                busy_q,      busy_d;
  logic [DATA_W-1:0]   rd_data_q,   rd_data_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
`ifdef PLYR_HIT_CNT_EN
  logic [7:0]          hit_count_q, hit_count_d;
`endif

  // The generator may only write while the FSM is not touching memory.
  assign obj_ready = (state_q == S_IDLE) || (state_q == S_DONE);

  // Next-state, memory update and registered-output computation.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    cur_addr_d  = cur_addr_q;
    cur_valid_d = cur_valid_q;
    rd_int_d    = rd_int_q;
    hit_d       = 1'b0;
    done_d      = 1'b0;
    mem_d       = mem_q;
    rd_data_d   = mem_q[rd_addr];
`ifdef PLYR_HIT_CNT_EN
    hit_count_d = hit_count_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (go_plyr) begin
          req_addr_d = plyr_addr;
          req_data_d = plyr_data;
          state_d    = S_ERASE;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_ERASE: begin
        if (cur_valid_q) begin
          mem_d[cur_addr_q] = {DATA_W{1'b0}};
        end else begin
          mem_d[cur_addr_q] = mem_q[cur_addr_q];
        end
        state_d = S_READ;
      end
      S_READ: begin
        rd_int_d = mem_q[req_addr_q];
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        // A same-cell move reads the cell just erased, so the address test
        // only matters if an object was written there in between.
        if ((rd_int_q != {DATA_W{1'b0}}) &&
            (!cur_valid_q || (req_addr_q != cur_addr_q))) begin
          hit_d = 1'b1;
`ifdef PLYR_HIT_CNT_EN
          if (hit_count_q != 8'hFF) begin
            hit_count_d = hit_count_q + 8'd1;
          end else begin
            hit_count_d = hit_count_q;
          end
`endif
        end else begin
          hit_d = 1'b0;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_d[req_addr_q] = req_data_q;
        cur_addr_d        = req_addr_q;
        cur_valid_d       = 1'b1;
        done_d            = 1'b1;
        state_d           = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Object writes only land in IDLE/DONE, where the FSM never writes
    // memory, so there is no same-edge conflict with the player path.
    if (obj_we && obj_ready) begin
      mem_d[obj_addr] = obj_data;
    end else begin
      mem_d[obj_addr] = mem_d[obj_addr];
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, request context, frame memory and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_addr_q  <= {ADDR_W{1'b0}};
      req_data_q  <= {DATA_W{1'b0}};
      cur_addr_q  <= {ADDR_W{1'b0}};
      cur_valid_q <= 1'b0;
      rd_int_q    <= {DATA_W{1'b0}};
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_data_q   <= {DATA_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
`ifdef PLYR_HIT_CNT_EN
      hit_count_q <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      cur_addr_q  <= cur_addr_d;
      cur_valid_q <= cur_valid_d;
      rd_int_q    <= rd_int_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      rd_data_q   <= rd_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
`ifdef PLYR_HIT_CNT_EN
      hit_count_q <= hit_count_d;
`endif
    end
  end

  assign done_plyr = done_q;
  assign busy      = busy_q;
  assign hit       = hit_q;
  assign rd_data   = rd_data_q;
`ifdef PLYR_HIT_CNT_EN
  assign hit_count = hit_count_q;
`else
  assign hit_count = 8'd0;
`endif

endmodule

// File: tb/tb_plyr_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_plyr_frame_writer
//
// Randomized self-checking bench for plyr_frame_writer. A reference model
// keeps the frame as a plain array plus the catcher position and applies
// each request as one atomic step (object write, erase, hit test, write).
// Cycle-level expectations come from the request timeline: hit in cycle 3,
// done in cycle 4, idle again in cycle 5 after the sampling edge.
// ---------------------------------------------------------------------------
module tb_plyr_frame_writer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       go_plyr = 1'b0;
  logic [5:0] plyr_addr = 6'd0;
  logic [7:0] plyr_data = 8'd0;
  logic       done_plyr;
  logic       busy;
  logic       hit;
  logic [7:0] hit_count;
  logic       obj_we = 1'b0;
  logic [5:0] obj_addr = 6'd0;
  logic [7:0] obj_data = 8'd0;
  logic       obj_ready;
  logic [5:0] rd_addr = 6'd0;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [7:0] m_mem [64];
  logic [5:0] m_cur;
  bit         m_cur_valid;
  int         m_cnt;

  plyr_frame_writer dut (
    .clock     (clock),
    .reset     (reset),
    .go_plyr   (go_plyr),
    .plyr_addr (plyr_addr),
    .plyr_data (plyr_data),
    .done_plyr (done_plyr),
    .busy      (busy),
    .hit       (hit),
    .hit_count (hit_count),
    .obj_we    (obj_we),
    .obj_addr  (obj_addr),
    .obj_data  (obj_data),
    .obj_ready (obj_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_count();
`ifdef PLYR_HIT_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 8'd0;
    m_cur       = 6'd0;
    m_cur_valid = 1'b0;
    m_cnt       = 0;
  endfunction

  // Called at a negedge; reads every cell through the scanner port.
  task automatic sweep_mem(input string tag);
    for (int a = 0; a < 64; a++) begin
      rd_addr = a[5:0];
      @(negedge clock);
      check_value(tag, {24'd0, rd_data}, {24'd0, m_mem[a]});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_done"},  {31'd0, done_plyr}, 32'd0);
    check_value({tag, "_busy"},  {31'd0, busy},      32'd0);
    check_value({tag, "_hit"},   {31'd0, hit},       32'd0);
    check_value({tag, "_cnt"},   {24'd0, hit_count}, 32'd0);
    check_value({tag, "_rdy"},   {31'd0, obj_ready}, 32'd1);
    check_value({tag, "_rdata"}, {24'd0, rd_data},   32'd0);
  endtask

  // Called at a negedge, returns at the negedge 5 cycles after the sampling
  // edge. Optionally performs an object write on the capture edge and the
  // dropped/accepted object-write probe during the transaction.
  task automatic run_txn(input logic [5:0] a, input logic [7:0] d, input bit hold,
                         input bit ow, input logic [5:0] oa, input logic [7:0] od,
                         input bit probe);
    bit exp_hit;
    go_plyr   = 1'b1;
    plyr_addr = a;
    plyr_data = d;
    obj_we    = ow;
    obj_addr  = oa;
    obj_data  = od;
    if (ow) m_mem[oa] = od;
    if (m_cur_valid) m_mem[m_cur] = 8'd0;
    exp_hit = (m_mem[a] != 8'd0) && (!m_cur_valid || (a != m_cur));
    m_mem[a]    = d;
    m_cur       = a;
    m_cur_valid = 1'b1;
    if (exp_hit && m_cnt < 255) m_cnt++;
    @(posedge clock);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clock);
      check_value("hit",       {31'd0, hit},       {31'd0, (k == 3) && exp_hit});
      check_value("done_plyr", {31'd0, done_plyr}, {31'd0, k == 4});
      check_value("busy",      {31'd0, busy},      {31'd0, k < 5});
      check_value("obj_ready", {31'd0, obj_ready}, {31'd0, k >= 4});
      if (k == 0) begin
        if (!hold) go_plyr = 1'b0;
        obj_we = 1'b0;
      end
      if (probe) begin
        if (k == 1) begin
          obj_we = 1'b1; obj_addr = 6'd20; obj_data = 8'hA5;
        end else if (k == 4) begin
          obj_we = 1'b1; obj_addr = 6'd21; obj_data = 8'h3C;
          m_mem[21] = 8'h3C;
        end else begin
          obj_we = 1'b0;
        end
      end
    end
    obj_we = 1'b0;
    check_value("hit_count", {24'd0, hit_count}, exp_count());
  endtask

  initial begin
    logic [5:0] ra;
    logic [7:0] rd;
    model_reset();

    // reset state
    repeat (2) @(negedge clock);
    check_idle_outputs("rst_active");
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("rst_release");
    sweep_mem("rst_mem");

    // first request: nothing to erase, no hit
    run_txn(6'd0, 8'hFF, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);
    sweep_mem("first_mem");

    // move: previous cell erased
    run_txn(6'd1, 8'hFF, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);

    // object placed in IDLE, then catch it
    obj_we = 1'b1; obj_addr = 6'd9; obj_data = 8'h01;
    @(negedge clock);
    obj_we = 1'b0;
    m_mem[9] = 8'h01;
    run_txn(6'd9, 8'h5A, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);
    sweep_mem("catch_mem");

    // held request on one cell, object write probe in READ and DONE
    run_txn(6'd5, 8'h80, 1'b1, 1'b0, 6'd0, 8'd0, 1'b1);
    run_txn(6'd5, 8'h80, 1'b1, 1'b0, 6'd0, 8'd0, 1'b0);
    run_txn(6'd5, 8'h80, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);
    sweep_mem("hold_mem");

    // randomized requests with same-edge object writes
    for (int i = 0; i < 40; i++) begin
      ra = 6'($urandom_range(0, 63));
      rd = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1)
        run_txn(ra, rd, 1'b0, 1'b1,
                ($urandom_range(0, 1) == 1) ? ra : 6'($urandom_range(0, 63)),
                8'($urandom_range(0, 255)), 1'b0);
      else
        run_txn(ra, rd, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);
    end
    sweep_mem("rand_mem");

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      ra = (i % 2 == 0) ? 6'd10 : 6'd11;
      run_txn(ra, 8'h02, 1'b0, 1'b1, ra, 8'h01, 1'b0);
    end
`ifdef PLYR_HIT_CNT_EN
    check_value("hit_count_sat", {24'd0, hit_count}, 32'd255);
`else
    check_value("hit_count_off", {24'd0, hit_count}, 32'd0);
`endif

    // reset during CHECK
    go_plyr = 1'b1; plyr_addr = 6'd30; plyr_data = 8'h77;
    @(posedge clock);
    @(negedge clock);
    go_plyr = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check_idle_outputs("after_rst");
    sweep_mem("midrst_mem");
    run_txn(6'd0, 8'hFF, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);
    run_txn(6'd1, 8'hFF, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);
    sweep_mem("post_rst_mem");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
